dmem_lsu: RTL and testbench

//  Load/store unit between the bitsliced datapath and a variable-latency data memory.

---
 rtl/dmem_lsu.sv | 177 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit: turns a datapath load/store into one word-aligned memory
// request with byte enables. It stalls the core while the request is
// outstanding, and it returns load data shifted right so the byte or halfword
// of interest sits at bit 0.
//
// Handshake: the controller raises lsu_read/lsu_write for the access. The
// requesting cycle already sees lsu_stall. Exactly one of lsu_done,
// lsu_misaligned or lsu_timeout then pulses for one cycle to end the access.
// On the memory side, mem_* is driven only in WAIT. The memory answers with a
// single-cycle mem_resp, which is sampled on the rising edge.
module dmem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_read,
    input  logic        lsu_write,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_misaligned,
    output logic        lsu_timeout,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [29:0]   waddr_q;
    logic [1:0]    off_q;
    logic          store_q;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q;

    logic          req;
    logic          aligned;
    logic [3:0]    req_mask;
    logic [31:0]   req_wdata;
    logic          capture;
    logic          in_wait;

    // funct3[2] only selects sign extension, and the datapath does that.
    logic unused_funct3;
    assign unused_funct3 = lsu_funct3[2];

    // Decode the incoming request: alignment, byte enables and the lane-shifted store data.
    always_comb begin
        req       = lsu_read | lsu_write;
        aligned   = 1'b0;
        req_mask  = 4'b1111;
        req_wdata = lsu_wdata << {lsu_addr[1:0], 3'b000};
        case (lsu_funct3[1:0])
            2'b00: begin
                aligned  = 1'b1;
                req_mask = 4'b0001 << lsu_addr[1:0];
            end
            2'b01: begin
                aligned  = ~lsu_addr[0];
                req_mask = 4'b0011 << lsu_addr[1:0];
            end
            2'b10: begin
                aligned  = (lsu_addr[1:0] == 2'b00);
                req_mask = 4'b1111;
            end
            default: aligned = 1'b0;
        endcase
    end

    // Next-state logic, response capture and the timeout counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        rdata_d   = rdata_q;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (aligned) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        capture = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (mem_resp) begin
                    // A response on the same edge as the limit still completes the access.
                    if (!store_q) begin
                        rdata_d = mem_rdata >> {off_q, 3'b000};
                    end
                    state_d = S_DONE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, timeout pulse and the held load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
        end
    end

    // Request fields are latched once, so the memory sees stable values for the whole WAIT dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_q <= '0;
            off_q   <= '0;
            store_q <= 1'b0;
            mask_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            waddr_q <= lsu_addr[31:2];
            off_q   <= lsu_addr[1:0];
            store_q <= lsu_write;
            mask_q  <= req_mask;
            wdata_q <= req_wdata;
        end
    end

    // Output drive: memory signals are forced to zero outside WAIT.
    always_comb begin
        in_wait        = (state_q == S_WAIT);
        mem_addr       = in_wait ? {waddr_q, 2'b00} : 32'd0;
        mem_rmask      = (in_wait && !store_q) ? mask_q : 4'd0;
        mem_wmask      = (in_wait && store_q) ? mask_q : 4'd0;
        mem_wdata      = in_wait ? wdata_q : 32'd0;
        lsu_stall      = ((state_q == S_IDLE) && req && aligned) || in_wait;
        lsu_done       = (state_q == S_DONE);
        lsu_misaligned = (state_q == S_ERR);
        lsu_timeout    = timeout_q;
        lsu_rdata      = rdata_q;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu with a short timeout (4). The driver issues directed
// accesses and pushes the expected end-of-access event into exp_q. It also
// checks the memory-side signals cycle by cycle. The monitor pops exp_q
// whenever the DUT pulses done, misaligned or timeout.
module tb_dmem_lsu;

    localparam int T = 4;
    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_MIS  = 3'b010;
    localparam logic [2:0] K_TO   = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_read = 1'b0;
    logic        lsu_write = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'd0;
    logic [31:0] lsu_wdata = 32'd0;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_misaligned;
    logic        lsu_timeout;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_resp = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];

    dmem_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .lsu_read(lsu_read), .lsu_write(lsu_write), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .lsu_misaligned(lsu_misaligned), .lsu_timeout(lsu_timeout),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every end-of-access pulse must match the oldest expected event.
    always @(negedge clk) begin
        logic [34:0] e;
        logic [2:0]  kind;
        kind = {lsu_timeout, lsu_misaligned, lsu_done};
        if (rst && kind != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(kind), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(kind), 32'(e[34:32]));
                chk("event_rdata", lsu_rdata, e[31:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem_idle(input string tag);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_rmask"}, 32'(mem_rmask), 32'd0);
        chk({tag, "_wmask"}, 32'(mem_wmask), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    // Request cycle: drive the access for one cycle and check the combinational stall.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic exp_stall);
        lsu_read = rd; lsu_write = wr; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        #3;
        chk("req_stall", 32'(lsu_stall), 32'(exp_stall));
        chk_mem_idle("req");
        next_cycle();
        lsu_read = 1'b0; lsu_write = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
    endtask

    // WAIT dwell of 'delay' cycles; the response arrives in the last one. Then the DONE cycle.
    task automatic serve(input int delay, input logic [31:0] mrd, input logic [31:0] ea,
                         input logic [3:0] er, input logic [3:0] ew, input logic [31:0] ewd);
        for (int i = 1; i <= delay; i++) begin
            if (i == delay) begin
                mem_resp = 1'b1; mem_rdata = mrd;
            end
            #3;
            chk("wait_stall", 32'(lsu_stall), 32'd1);
            chk("wait_addr", mem_addr, ea);
            chk("wait_rmask", 32'(mem_rmask), 32'(er));
            chk("wait_wmask", 32'(mem_wmask), 32'(ew));
            chk("wait_wdata", mem_wdata, ewd);
            next_cycle();
            mem_resp = 1'b0; mem_rdata = 32'd0;
        end
        #3;
        chk("done_stall", 32'(lsu_stall), 32'd0);
        chk_mem_idle("done");
        next_cycle();
    endtask

    // ERR cycle following a rejected request.
    task automatic reject();
        #3;
        chk("err_stall", 32'(lsu_stall), 32'd0);
        chk_mem_idle("err");
        next_cycle();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_pulses", 32'({lsu_timeout, lsu_misaligned, lsu_done}), 32'd0);
        chk_mem_idle("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        next_cycle();

        // LW 0x100: response three WAIT cycles later
        exp_q.push_back({K_DONE, 32'hDEADBEEF});
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b1);
        serve(3, 32'hDEADBEEF, 32'h100, 4'b1111, 4'b0000, 32'd0);
        chk("lw_rdata", lsu_rdata, 32'hDEADBEEF);

        // LB 0x103: top byte lane, shifted down
        exp_q.push_back({K_DONE, 32'h00000080});
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 1'b1);
        serve(1, 32'h80112233, 32'h100, 4'b1000, 4'b0000, 32'd0);

        // SH 0x102: upper half lanes; the load result is left untouched
        exp_q.push_back({K_DONE, 32'h00000080});
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1'b1);
        serve(2, 32'h12345678, 32'h100, 4'b0000, 4'b1100, 32'hABCD0000);

        // Misaligned LW 0x101 and LH 0x203
        exp_q.push_back({K_MIS, 32'h00000080});
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 1'b0);
        reject();
        exp_q.push_back({K_MIS, 32'h00000080});
        issue(1'b1, 1'b0, 3'b001, 32'h203, 32'd0, 1'b0);
        reject();

        // LHU 0x202 (funct3 bit2 set)
        exp_q.push_back({K_DONE, 32'h0000BEEF});
        issue(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 1'b1);
        serve(1, 32'hBEEF1234, 32'h200, 4'b1100, 4'b0000, 32'd0);

        // Size 11 is always rejected
        exp_q.push_back({K_MIS, 32'h0000BEEF});
        issue(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 1'b0);
        reject();

        // Read and write together: treated as store SB 0x001
        exp_q.push_back({K_DONE, 32'h0000BEEF});
        issue(1'b1, 1'b1, 3'b000, 32'h001, 32'h0000005A, 1'b1);
        serve(1, 32'hFFFFFFFF, 32'h000, 4'b0000, 4'b0010, 32'h00005A00);

        // Timeout: LW 0x300, never answered
        exp_q.push_back({K_TO, 32'h0000BEEF});
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b1);
        for (int i = 1; i <= T; i++) begin
            #3;
            chk("to_wait_stall", 32'(lsu_stall), 32'd1);
            chk("to_wait_rmask", 32'(mem_rmask), 32'hF);
            next_cycle();
        end
        #3;
        chk("to_stall", 32'(lsu_stall), 32'd0);
        chk_mem_idle("to");
        next_cycle();

        // Response on the last allowed WAIT cycle wins over the timeout
        exp_q.push_back({K_DONE, 32'h11223344});
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 1'b1);
        serve(T, 32'h11223344, 32'h400, 4'b1111, 4'b0000, 32'd0);

        // Stray response while idle is ignored
        mem_resp = 1'b1; mem_rdata = 32'hFFFFFFFF;
        next_cycle();
        mem_resp = 1'b0; mem_rdata = 32'd0;
        #3;
        chk("idle_resp_rdata", lsu_rdata, 32'h11223344);
        next_cycle();

        // Reset during WAIT, then a late response, then a normal load
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 1'b1);
        #2;
        chk("pre_rst_rmask", 32'(mem_rmask), 32'hF);
        rst = 1'b0;
        #1;
        chk("arst_rmask", 32'(mem_rmask), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_stall", 32'(lsu_stall), 32'd0);
        chk("arst_rdata", lsu_rdata, 32'd0);
        next_cycle();
        rst = 1'b1;
        mem_resp = 1'b1; mem_rdata = 32'h99999999;
        next_cycle();
        mem_resp = 1'b0; mem_rdata = 32'd0;
        #3;
        chk("late_resp_rdata", lsu_rdata, 32'd0);
        chk("late_resp_stall", 32'(lsu_stall), 32'd0);
        next_cycle();
        exp_q.push_back({K_DONE, 32'hCAFEF00D});
        issue(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 1'b1);
        serve(1, 32'hCAFEF00D, 32'h600, 4'b1111, 4'b0000, 32'd0);

        next_cycle();
        chk("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
